sevseg_ctrl: RTL and testbench

SEVSEG_CTRL -- requirements
Module: sevseg_ctrl

---
 rtl/sevseg_ctrl.sv | 173 +++++++++++++++++
 tb/tb_sevseg_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sevseg_ctrl.sv
// Four-digit multiplexed 7-segment hex controller with two double-buffered
// sources and frame-synchronous page rotation. Optional macro: SEVSEG_LZB_EN.
module sevseg_ctrl #(
  parameter int unsigned SCAN_DIV    = 1000,
  parameter int unsigned HOLD_FRAMES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] s0_data,
  input  logic        s0_valid,
  output logic        s0_ready,
  input  logic [15:0] s1_data,
  input  logic        s1_valid,
  output logic        s1_ready,
  input  logic        hold,
  output logic [3:0]  an,
  output logic [3:0]  nib,
  output logic        page,
  output logic        frame_tick
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned FW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  typedef enum logic {
    SHOW0 = 1'b0,
    SHOW1 = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [DW-1:0]   r_div_cnt;
  logic [1:0]      r_digit;
  logic [FW-1:0]   r_frame_cnt;
  logic [FW-1:0]   w_frame_cnt_nxt;
  logic            r_frame_tick;
  logic [15:0]     r_pend [2];
  logic [15:0]     r_pg   [2];
  logic [1:0]      r_pend_v;
  logic [1:0]      r_loaded;
  logic [1:0]      r_ready;
  logic [3:0]      r_an;
  logic [3:0]      r_nib;

  logic            w_div_wrap;
  logic            w_boundary;
  logic [15:0]     w_data [2];
  logic [1:0]      w_valid;
  logic [1:0]      w_accept;
  logic [1:0]      w_pend_v_nxt;
  logic [15:0]     w_page_data;
  logic [3:0]      w_nib;
  logic [3:0]      w_an_dec;
  logic            w_blank;

  assign w_div_wrap = (r_div_cnt == DW'(SCAN_DIV - 1));
  assign w_boundary = w_div_wrap && (r_digit == 2'd3);

  assign w_data[0]  = s0_data;
  assign w_data[1]  = s1_data;
  assign w_valid    = {s1_valid, s0_valid};
  assign w_accept   = w_valid & r_ready;

  // A slot emptied at this boundary only refills from a later handshake, so
  // data accepted on the boundary cycle waits for the following boundary.
  always_comb begin
    w_pend_v_nxt = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      w_pend_v_nxt[i] = (r_pend_v[i] && !w_boundary) || w_accept[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div_cnt    <= '0;
      r_digit      <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_div_cnt    <= w_div_wrap ? '0 : r_div_cnt + 1'b1;
      if (w_div_wrap) begin
        r_digit <= r_digit + 1'b1;
      end
      r_frame_tick <= w_boundary;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend_v <= '0;
      r_loaded <= '0;
      r_ready  <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_pend[i] <= '0;
        r_pg[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (w_boundary && r_pend_v[i]) begin
          r_pg[i]     <= r_pend[i];
          r_loaded[i] <= 1'b1;
        end
        if (w_accept[i]) begin
          r_pend[i] <= w_data[i];
        end
      end
      r_pend_v <= w_pend_v_nxt;
      r_ready  <= ~w_pend_v_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= SHOW0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_frame_cnt_nxt = r_frame_cnt;
    if (w_boundary && !hold) begin
      if (r_frame_cnt == FW'(HOLD_FRAMES - 1)) begin
        w_frame_cnt_nxt = '0;
        case (r_state)
          SHOW0:   if (r_loaded[1]) w_state_nxt = SHOW1;
          SHOW1:   if (r_loaded[0]) w_state_nxt = SHOW0;
          default: w_state_nxt = SHOW0;
        endcase
      end else begin
        w_frame_cnt_nxt = r_frame_cnt + 1'b1;
      end
    end
  end

  assign w_page_data = (r_state == SHOW1) ? r_pg[1] : r_pg[0];
  assign w_nib       = w_page_data[{r_digit, 2'b00} +: 4];
  assign w_an_dec    = ~(4'b0001 << r_digit);

`ifdef SEVSEG_LZB_EN
  always_comb begin
    w_blank = 1'b0;
    case (r_digit)
      2'd1:    w_blank = (w_page_data[15:4]  == '0);
      2'd2:    w_blank = (w_page_data[15:8]  == '0);
      2'd3:    w_blank = (w_page_data[15:12] == '0);
      default: w_blank = 1'b0;
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_an  <= '1;
      r_nib <= '0;
    end else begin
      r_an  <= w_blank ? '1 : w_an_dec;
      r_nib <= w_nib;
    end
  end

  assign an         = r_an;
  assign nib        = r_nib;
  assign page       = (r_state == SHOW1);
  assign frame_tick = r_frame_tick;
  assign s0_ready   = r_ready[0];
  assign s1_ready   = r_ready[1];

endmodule

// File: tb/tb_sevseg_ctrl.sv
// Directed vector bench for sevseg_ctrl at SCAN_DIV=4, HOLD_FRAMES=2;
// expected an on blanked digits follows SEVSEG_LZB_EN.
module tb_sevseg_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] s0_data;
  logic        s0_valid;
  logic        s0_ready;
  logic [15:0] s1_data;
  logic        s1_valid;
  logic        s1_ready;
  logic        hold;
  logic [3:0]  an;
  logic [3:0]  nib;
  logic        page;
  logic        frame_tick;

  int unsigned n_cmp;
  int unsigned n_err;

  sevseg_ctrl #(
    .SCAN_DIV    (4),
    .HOLD_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s0_data    (s0_data),
    .s0_valid   (s0_valid),
    .s0_ready   (s0_ready),
    .s1_data    (s1_data),
    .s1_valid   (s1_valid),
    .s1_ready   (s1_ready),
    .hold       (hold),
    .an         (an),
    .nib        (nib),
    .page       (page),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

`ifdef SEVSEG_LZB_EN
  localparam logic [3:0] AN_D1 = 4'b1111;
  localparam logic [3:0] AN_D2 = 4'b1111;
  localparam logic [3:0] AN_D3 = 4'b1111;
`else
  localparam logic [3:0] AN_D1 = 4'b1101;
  localparam logic [3:0] AN_D2 = 4'b1011;
  localparam logic [3:0] AN_D3 = 4'b0111;
`endif

  typedef struct {
    int unsigned adv;
    logic        rst;
    logic        s0v;
    logic [15:0] s0d;
    logic        s1v;
    logic [15:0] s1d;
    logic        hld;
    logic [3:0]  an;
    logic [3:0]  nib;
    logic        pg;
    logic        tk;
    logic        r0;
    logic        r1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int unsigned adv, logic rst, logic s0v, logic [15:0] s0d,
                              logic s1v, logic [15:0] s1d, logic hld, logic [3:0] e_an,
                              logic [3:0] e_nib, logic pg, logic tk, logic r0, logic r1);
    vec_t v;
    v.adv = adv; v.rst = rst; v.s0v = s0v; v.s0d = s0d; v.s1v = s1v; v.s1d = s1d;
    v.hld = hld; v.an = e_an; v.nib = e_nib; v.pg = pg; v.tk = tk; v.r0 = r0; v.r1 = r1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    int unsigned waited;
    logic        seen;
    clk = 1'b0; rst_n = 1'b0; hold = 1'b0;
    s0_valid = 1'b0; s0_data = '0; s1_valid = 1'b0; s1_data = '0;
    n_cmp = 0; n_err = 0;

    // k = cycles after the first released edge; boundaries land on k = 16m+15
    //            adv rst s0v s0d      s1v s1d      hld an       nib   pg tk r0 r1
    vecs.push_back(mk(1,  1, 1, 16'hBEEF, 0, 16'h0000, 0, 4'b1110, 4'h0, 0, 0, 1, 1)); // k=0
    vecs.push_back(mk(4,  1, 0, 16'h0000, 0, 16'h0000, 0, 4'b1101, 4'h0, 0, 0, 1, 1)); // 4
    vecs.push_back(mk(4,  1, 0, 16'h0000, 0, 16'h0000, 0, 4'b1011, 4'h0, 0, 0, 1, 1)); // 8
    vecs.push_back(mk(3,  1, 0, 16'h0000, 0, 16'h0000, 0, 4'b1011, 4'h0, 0, 0, 1, 1)); // 11
    vecs.push_back(mk(1,  1, 0, 16'h0000, 0, 16'h0000, 0, 4'b0111, 4'h0, 0, 0, 1, 1)); // 12
    vecs.push_back(mk(3,  1, 0, 16'h0000, 0, 16'h0000, 0, 4'b0111, 4'h0, 0, 1, 1, 1)); // 15
    vecs.push_back(mk(1,  1, 0, 16'h0000, 0, 16'h0000, 0, 4'b1110, 4'h0, 0, 0, 1, 1)); // 16
    vecs.push_back(mk(1,  1, 1, 16'h1A2F, 0, 16'h0000, 0, 4'b1110, 4'h0, 0, 0, 0, 1)); // 17
    vecs.push_back(mk(8,  1, 0, 16'h0000, 0, 16'h0000, 0, 4'b1011, 4'h0, 0, 0, 0, 1)); // 25
    vecs.push_back(mk(6,  1, 0, 16'h0000, 0, 16'h0000, 0, 4'b0111, 4'h0, 0, 1, 1, 1)); // 31
    vecs.push_back(mk(1,  1, 0, 16'h0000, 0, 16'h0000, 0, 4'b1110, 4'hF, 0, 0, 1, 1)); // 32
    vecs.push_back(mk(4,  1, 0, 16'h0000, 0, 16'h0000, 0, 4'b1101, 4'h2, 0, 0, 1, 1)); // 36
    vecs.push_back(mk(4,  1, 0, 16'h0000, 0, 16'h0000, 0, 4'b1011, 4'hA, 0, 0, 1, 1)); // 40
    vecs.push_back(mk(4,  1, 0, 16'h0000, 0, 16'h0000, 0, 4'b0111, 4'h1, 0, 0, 1, 1)); // 44
    vecs.push_back(mk(2,  1, 0, 16'h0000, 0, 16'h0000, 0, 4'b0111, 4'h1, 0, 0, 1, 1)); // 46
    vecs.push_back(mk(1,  1, 0, 16'h0000, 1, 16'h2222, 0, 4'b0111, 4'h1, 0, 1, 1, 0)); // 47
    vecs.push_back(mk(15, 1, 0, 16'h0000, 0, 16'h0000, 0, 4'b0111, 4'h1, 0, 0, 1, 0)); // 62
    vecs.push_back(mk(1,  1, 0, 16'h0000, 0, 16'h0000, 0, 4'b0111, 4'h1, 0, 1, 1, 1)); // 63
    vecs.push_back(mk(16, 1, 0, 16'h0000, 0, 16'h0000, 0, 4'b0111, 4'h1, 0, 1, 1, 1)); // 79
    vecs.push_back(mk(15, 1, 0, 16'h0000, 0, 16'h0000, 0, 4'b0111, 4'h1, 0, 0, 1, 1)); // 94
    vecs.push_back(mk(1,  1, 0, 16'h0000, 0, 16'h0000, 0, 4'b0111, 4'h1, 1, 1, 1, 1)); // 95
    vecs.push_back(mk(1,  1, 0, 16'h0000, 0, 16'h0000, 0, 4'b1110, 4'h2, 1, 0, 1, 1)); // 96
    vecs.push_back(mk(31, 1, 0, 16'h0000, 0, 16'h0000, 0, 4'b0111, 4'h2, 0, 1, 1, 1)); // 127
    vecs.push_back(mk(1,  1, 0, 16'h0000, 0, 16'h0000, 0, 4'b1110, 4'hF, 0, 0, 1, 1)); // 128
    vecs.push_back(mk(1,  1, 1, 16'h1111, 0, 16'h0000, 1, 4'b1110, 4'hF, 0, 0, 0, 1)); // 129
    vecs.push_back(mk(14, 1, 0, 16'h0000, 0, 16'h0000, 1, 4'b0111, 4'h1, 0, 1, 1, 1)); // 143
    vecs.push_back(mk(1,  1, 0, 16'h0000, 0, 16'h0000, 1, 4'b1110, 4'h1, 0, 0, 1, 1)); // 144
    vecs.push_back(mk(63, 1, 0, 16'h0000, 0, 16'h0000, 1, 4'b0111, 4'h1, 0, 1, 1, 1)); // 207
    vecs.push_back(mk(81, 1, 0, 16'h0000, 0, 16'h0000, 1, 4'b1110, 4'h1, 0, 0, 1, 1)); // 288
    vecs.push_back(mk(30, 1, 0, 16'h0000, 0, 16'h0000, 0, 4'b0111, 4'h1, 0, 0, 1, 1)); // 318
    vecs.push_back(mk(1,  1, 0, 16'h0000, 0, 16'h0000, 0, 4'b0111, 4'h1, 1, 1, 1, 1)); // 319
    vecs.push_back(mk(1,  1, 0, 16'h0000, 0, 16'h0000, 0, 4'b1110, 4'h2, 1, 0, 1, 1)); // 320
    vecs.push_back(mk(1,  0, 0, 16'h0000, 0, 16'h0000, 0, 4'b1111, 4'h0, 0, 0, 0, 0)); // reset
    vecs.push_back(mk(2,  0, 0, 16'h0000, 0, 16'h0000, 0, 4'b1111, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk(1,  1, 0, 16'h0000, 0, 16'h0000, 0, 4'b1110, 4'h0, 0, 0, 1, 1)); // k'=0
    vecs.push_back(mk(1,  1, 1, 16'h0005, 0, 16'h0000, 0, 4'b1110, 4'h0, 0, 0, 0, 1)); // 1
    vecs.push_back(mk(3,  1, 0, 16'h0000, 0, 16'h0000, 0, 4'b1101, 4'h0, 0, 0, 0, 1)); // 4
    vecs.push_back(mk(11, 1, 0, 16'h0000, 0, 16'h0000, 0, 4'b0111, 4'h0, 0, 1, 1, 1)); // 15
    vecs.push_back(mk(1,  1, 0, 16'h0000, 0, 16'h0000, 0, 4'b1110, 4'h5, 0, 0, 1, 1)); // 16
    vecs.push_back(mk(4,  1, 0, 16'h0000, 0, 16'h0000, 0, AN_D1,   4'h0, 0, 0, 1, 1)); // 20
    vecs.push_back(mk(4,  1, 0, 16'h0000, 0, 16'h0000, 0, AN_D2,   4'h0, 0, 0, 1, 1)); // 24
    vecs.push_back(mk(4,  1, 0, 16'h0000, 0, 16'h0000, 0, AN_D3,   4'h0, 0, 0, 1, 1)); // 28

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.an",    an,                4'b1111);
    chk("rst.nib",   nib,               4'h0);
    chk("rst.page",  {3'b000, page},    4'h0);
    chk("rst.tick",  {3'b000, frame_tick}, 4'h0);
    chk("rst.rdy0",  {3'b000, s0_ready}, 4'h0);
    chk("rst.rdy1",  {3'b000, s1_ready}, 4'h0);

    foreach (vecs[i]) begin
      rst_n    = vecs[i].rst;
      s0_valid = vecs[i].s0v;
      s0_data  = vecs[i].s0d;
      s1_valid = vecs[i].s1v;
      s1_data  = vecs[i].s1d;
      hold     = vecs[i].hld;
      repeat (vecs[i].adv) @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d.an", i),   an,                     vecs[i].an);
      chk($sformatf("v%0d.nib", i),  nib,                    vecs[i].nib);
      chk($sformatf("v%0d.page", i), {3'b000, page},         {3'b000, vecs[i].pg});
      chk($sformatf("v%0d.tick", i), {3'b000, frame_tick},   {3'b000, vecs[i].tk});
      chk($sformatf("v%0d.rdy0", i), {3'b000, s0_ready},     {3'b000, vecs[i].r0});
      chk($sformatf("v%0d.rdy1", i), {3'b000, s1_ready},     {3'b000, vecs[i].r1});
    end

    // Only page 0 holds data after the reset: rotation must never leave it.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("solo.tick", {3'b000, frame_tick}, 4'h1);
    for (int j = 0; j < 6; j++) begin
      chk($sformatf("solo.page%0d", j), {3'b000, page}, 4'h0);
      repeat (16) @(posedge clk);
      @(negedge clk);
    end

    // Next frame tick must arrive within one frame period.
    @(posedge clk);
    @(negedge clk);
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < 20) begin
      @(posedge clk);
      @(negedge clk);
      waited++;
      if (frame_tick) seen = 1'b1;
    end
    chk("solo.tickwait", {3'b000, seen}, 4'h1);
    chk("solo.tickgap", waited[3:0], 4'd15);
    chk("solo.nib", nib, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
